// File: rtl/alu_lane_sequencer.sv
// Strip-mining controller for the vector ALU. It takes one vector operation and
// issues it in beats of LANES elements, then ORs together the per-lane flags.
module alu_lane_sequencer #(
  parameter int N     = 8,
  parameter int LANES = 6,
  parameter int LW    = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [LW-1:0]        op_len,
  input  logic [2:0]           op_ctrl,
  input  logic [1:0]           op_vsi,
  input  logic [3:0]           op_bidx,
  input  logic [N-1:0]         op_imm,
  output logic                 busy,
  output logic                 err,
  output logic                 issue_valid,
  input  logic                 issue_ready,
  output logic [LW-1:0]        base_idx,
  output logic [LANES-1:0]     lane_mask,
  output logic [2:0]           ALUControl,
  output logic [1:0]           VSIFlag,
  output logic [3:0]           SrcBiE,
  output logic [N-1:0]         Imm,
  input  logic [2*LANES-1:0]   ALUFlags_in,
  output logic [1:0]           flags_acc,
  output logic                 done
);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  localparam logic [LW:0] LANES_W = (LW+1)'(LANES);
  localparam logic [3:0]  LANES_B = 4'(LANES);

  state_t             state_q, state_d;
  logic [LW-1:0]      count_q, count_d;
  logic [LW-1:0]      len_q, len_d;
  logic [2:0]         ctrl_q, ctrl_d;
  logic [1:0]         vsi_q, vsi_d;
  logic [3:0]         bidx_q, bidx_d;
  logic [N-1:0]       imm_q, imm_d;
  logic [1:0]         flags_q, flags_d;
  logic               err_q, err_d;
  logic               busy_q, busy_d;
  logic               valid_q, valid_d;
  logic               done_q, done_d;
  logic [LW-1:0]      base_q, base_d;
  logic [LANES-1:0]   mask_q, mask_d;
  logic [1:0]         beat_flags;
  logic [LW:0]        next_count;
  logic               illegal;

  always_comb begin
    beat_flags = 2'b00;
    for (int i = 0; i < LANES; i++) begin
      if (mask_q[i]) beat_flags = beat_flags | ALUFlags_in[2*i +: 2];
    end
  end

  assign next_count = {1'b0, count_q} + LANES_W;
  assign illegal    = (op_vsi == 2'b11) || ((op_vsi == 2'b01) && (op_bidx >= LANES_B));

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    len_d   = len_q;
    ctrl_d  = ctrl_q;
    vsi_d   = vsi_q;
    bidx_d  = bidx_q;
    imm_d   = imm_q;
    flags_d = flags_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (illegal) begin
            err_d = 1'b1;
          end else begin
            len_d   = op_len;
            ctrl_d  = op_ctrl;
            vsi_d   = op_vsi;
            bidx_d  = op_bidx;
            imm_d   = op_imm;
            flags_d = 2'b00;
            count_d = '0;
            state_d = (op_len == '0) ? DONE : ISSUE;
          end
        end
      end
      ISSUE: begin
        if (issue_ready) begin
          flags_d = flags_q | beat_flags;
          count_d = next_count[LW-1:0];
          if (next_count >= {1'b0, len_q}) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are precomputed from the next state so they leave the flops directly.
    valid_d = (state_d == ISSUE);
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
    base_d  = valid_d ? count_d : '0;
    mask_d  = '0;
    for (int i = 0; i < LANES; i++) begin
      mask_d[i] = valid_d && (({1'b0, count_d} + (LW+1)'(i)) < {1'b0, len_d});
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      count_q <= '0;
      len_q   <= '0;
      ctrl_q  <= '0;
      vsi_q   <= '0;
      bidx_q  <= '0;
      imm_q   <= '0;
      flags_q <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      base_q  <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      len_q   <= len_d;
      ctrl_q  <= ctrl_d;
      vsi_q   <= vsi_d;
      bidx_q  <= bidx_d;
      imm_q   <= imm_d;
      flags_q <= flags_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      base_q  <= base_d;
      mask_q  <= mask_d;
    end
  end

  assign busy        = busy_q;
  assign err         = err_q;
  assign issue_valid = valid_q;
  assign base_idx    = base_q;
  assign lane_mask   = mask_q;
  assign ALUControl  = ctrl_q;
  assign VSIFlag     = vsi_q;
  assign SrcBiE      = bidx_q;
  assign Imm         = imm_q;
  assign flags_acc   = flags_q;
  assign done        = done_q;

endmodule

// File: doc/alu_lane_sequencer.md
Name: alu_lane_sequencer

Overview:
- Strip-mining controller for the 6-lane vector ALU datapath: accepts one vector operation of op_len elements and issues it in beats of LANES elements.
- Each beat drives base element index, lane enable mask and latched ALU control/operand-select fields.
- Accumulates the per-lane ALU flags of enabled lanes into a sticky summary; reports completion with a done pulse.
- Sits between the decode/issue stage and the lane array.

Parameters:
N, 8, data width of lanes / immediate
LANES, 6, number of ALU lanes
LW, 8, width of element count and index

Ports:
clk  input  1  clock, rising edge
reset_n  input  1  asynchronous active-low reset
start  input  1  request to begin an operation (sampled in IDLE only)
op_len  input  LW  element count, 0..2^LW-1
op_ctrl  input  3  ALU operation code
op_vsi  input  2  operand-B select: 00 lane-wise, 01 broadcast lane, 10 immediate, 11 illegal
op_bidx  input  4  broadcast lane index for op_vsi=01
op_imm  input  N  immediate operand
busy  output  1  operation in progress
err  output  1  one-cycle pulse: start rejected
issue_valid  output  1  beat presented to lanes
issue_ready  input  1  downstream accepts beat
base_idx  output  LW  element index of lane 0 for current beat
lane_mask  output  LANES  bit i = lane i holds a valid element
ALUControl  output  3  latched op_ctrl
VSIFlag  output  2  latched op_vsi
SrcBiE  output  4  latched op_bidx
Imm  output  N  latched op_imm
ALUFlags_in  input  LANES x 2  per-lane flags from lanes, same cycle as beat
flags_acc  output  2  OR of ALUFlags_in over all enabled lanes of all accepted beats
done  output  1  one-cycle completion pulse

Behaviour:
- Reset (async, reset_n=0): state IDLE. busy, err, issue_valid, done, base_idx, lane_mask, ALUControl, VSIFlag, SrcBiE, Imm and flags_acc all 0. Asserting reset mid-operation aborts immediately with no done pulse.
- States: IDLE, ISSUE, DONE.
- IDLE, start=1, illegal request:
  - Illegal means op_vsi=11, or op_vsi=01 with op_bidx>=LANES.
  - Response: err=1 for one cycle, stay IDLE, latched fields unchanged.
- IDLE, start=1, legal request:
  - Latch op_* fields; clear flags_acc; count:=0.
  - op_len=0: go to DONE. Otherwise go to ISSUE.
- busy=1 in ISSUE and DONE. start is ignored outside IDLE.
- ISSUE outputs:
  - issue_valid=1; base_idx=count.
  - lane_mask[i] = (count+i < len), computed in LW+1 bits; no wrap.
- ISSUE, issue_valid & issue_ready (beat accepted):
  - flags_acc |= OR over i of (lane_mask[i] ? ALUFlags_in[i] : 00).
  - count += LANES.
  - If count+LANES >= len (LW+1-bit compare): go to DONE.
- ISSUE, issue_ready=0: hold all outputs and count; no flag accumulation.
- DONE: issue_valid=0, lane_mask=0, done=1 for exactly one cycle, then IDLE with busy=0.
- flags_acc and latched fields persist after done until the next legal start is accepted.
- Timing:
  - start accepted at edge t gives first issue_valid in cycle t+1.
  - Beats = ceil(len/LANES).
  - With issue_ready held 1, done is high in cycle t+1+beats.
  - A new start is accepted no earlier than the cycle after done.
- All outputs registered or decoded from registered state only; no combinational path from start to issue_valid. ALUFlags_in is sampled only at accepted beats.

Test Plan:
- len=14, vsi=00, issue_ready=1: beats base 0/6/12, masks 3F/3F/03, done 4 cycles after start accept, busy falls with done.
- len=14, issue_ready low 2 cycles during beat 2: base_idx=6 and mask=3F held 3 cycles, flags not accumulated while stalled, done delayed by 2 cycles.
- len=0: no issue_valid, done pulse in cycle after accept, flags_acc=00.
- vsi=01, bidx=6: err pulse, busy=0, no beats. Then vsi=01, bidx=2, imm=0x5A, ctrl=3: SrcBiE=2, ALUControl=3, Imm=5A held through all beats.
- len=13, flag 10 on lane 4 only in final beat (mask 01): flags_acc=00. Repeat with flag on lane 0 of final beat: flags_acc=10. Start a new op: flags_acc clears to 00 on accept.
- len=255, LW=8: 43 beats, last base_idx=252 with mask 07, no wrap to 0. reset_n low during beat 20: all outputs 0 immediately, no done, next start accepted normally.
